// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: segment codes,
// conversion FSM states and the nibble-to-segment decoder.
package seven_seg_pkg;

    // Conversion FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } bcd_state_e;

    // Segment codes {p,g,f,e,d,c,b,a}, active-high; polarity is applied at the pins.
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam int         DP_BIT    = 7;

    // BCD nibble to segment pattern; non-decimal codes cannot occur and show blank.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_mux_n_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per cycle)
// with a one-deep "last wins" pending slot for loads that arrive while busy.
//
// Handshake: load is a single-cycle request with no ready; it is always
// accepted. In IDLE it starts a conversion, otherwise it overwrites the
// pending slot. commit is a one-cycle valid for bcd; there is no back-pressure.
module bin2bcd_seq import seven_seg_pkg::*; #(
    parameter int VALUE_W = 14,
    parameter int NIBBLES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VALUE_W-1:0]     value,
    input  logic                   load,
    output logic                   busy,
    output logic                   commit,
    output logic [NIBBLES*4-1:0]   bcd,
    output bcd_state_e             state
);

    localparam int BCD_W = NIBBLES * 4;
    localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

    bcd_state_e         state_q, state_d;
    logic [VALUE_W-1:0] sr_q, sr_d;
    logic [VALUE_W-1:0] pend_val_q, pend_val_d;
    logic               pend_q, pend_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   adj;

    // Next-state, datapath and pending-slot logic.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        adj        = '0;

        for (int i = 0; i < NIBBLES; i++) begin
            adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
        end

        if (load && (state_q != IDLE)) begin
            pend_d     = 1'b1;
            pend_val_d = value;
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    sr_d    = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {adj[BCD_W-2:0], sr_q[VALUE_W-1]};
                sr_d  = sr_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // A load landing on the commit cycle is the newest request, so it wins.
                if (pend_q || load) begin
                    sr_d    = load ? value : pend_val_q;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
                pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            bcd_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign commit = (state_q == COMMIT);
    assign bcd    = bcd_q;
    assign state  = state_q;

endmodule

// File: rtl/seven_seg_mux_n.sv
// N-digit multiplexed 7-segment driver: sequential BCD conversion, refresh
// scan, leading-zero blanking, decimal points, overflow dash and pin polarity.
module seven_seg_mux_n import seven_seg_pkg::*; #(
    parameter int DIGITS           = 4,
    parameter int VALUE_W          = 14,
    parameter int REFRESH_W        = 17,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    input  logic [DIGITS-1:0]  dp_mask,
    input  logic               blank_lz,
    input  logic               enable,
    output logic               busy,
    output logic               overflow,
    output logic [DIGITS-1:0]  digit,
    output logic [7:0]         segments,
    output logic [1:0]         dbg_state
);

    localparam int                NIBBLES   = DIGITS + 1;
    localparam int                IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] DIGIT_OFF = {DIGITS{DIGIT_ACTIVE_LOW}};
    localparam logic [7:0]        SEG_OFF   = {8{SEG_ACTIVE_LOW}};

    if (VALUE_W > 3 * (DIGITS + 1)) begin : g_bad_width
        $error("VALUE_W too wide for DIGITS+1 BCD nibbles");
    end

    logic                 commit;
    logic [NIBBLES*4-1:0] bcd;
    bcd_state_e           conv_state;

    bin2bcd_seq #(
        .VALUE_W (VALUE_W),
        .NIBBLES (NIBBLES)
    ) u_bin2bcd (
        .clk    (clk),
        .rst    (rst),
        .value  (value),
        .load   (load),
        .busy   (busy),
        .commit (commit),
        .bcd    (bcd),
        .state  (conv_state)
    );

    assign dbg_state = conv_state;

    logic [REFRESH_W-1:0] refresh_q, refresh_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DIGITS*4-1:0]  disp_q, disp_d;
    logic                 ovf_q, ovf_d;
    logic [DIGITS-1:0]    digit_q, digit_d;
    logic [7:0]           seg_q, seg_d;

    // Free-running refresh counter, MSB-first scan index and display capture on commit.
    always_comb begin
        refresh_d = refresh_q + REFRESH_W'(1);
        idx_d     = idx_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        if (&refresh_q) begin
            idx_d = (idx_q == '0) ? IDX_W'(DIGITS - 1) : idx_q - IDX_W'(1);
        end
        if (commit) begin
            disp_d = bcd[DIGITS*4-1:0];
            ovf_d  = |bcd[NIBBLES*4-1 -: 4];
        end
    end

    logic [3:0]        nib;
    logic              dp;
    logic              lead_zero;
    logic              upper_zero;
    logic [7:0]        seg_act;
    logic [DIGITS-1:0] dig_act;

    // Segment pattern for the scanned digit, then polarity and enable gating.
    always_comb begin
        nib        = 4'd0;
        dp         = 1'b0;
        lead_zero  = 1'b0;
        upper_zero = 1'b1;
        // Walk from the top nibble down so upper_zero covers nibbles k..DIGITS-1.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (disp_q[k*4 +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
            if (idx_q == IDX_W'(k)) begin
                nib       = disp_q[k*4 +: 4];
                dp        = dp_mask[k];
                lead_zero = upper_zero && (k != 0);
            end
        end

        if (ovf_q) begin
            seg_act = SEG_DASH;
        end else if (blank_lz && lead_zero) begin
            seg_act = SEG_BLANK;
        end else begin
            seg_act = seg_decode(nib);
        end
        seg_act[DP_BIT] = seg_act[DP_BIT] | dp;

        dig_act = DIGITS'(1) << idx_q;

        if (enable) begin
            digit_d = DIGIT_ACTIVE_LOW ? ~dig_act : dig_act;
            seg_d   = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
        end else begin
            digit_d = DIGIT_OFF;
            seg_d   = SEG_OFF;
        end
    end

    // Scan, display and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_q <= '0;
            idx_q     <= IDX_W'(DIGITS - 1);
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            digit_q   <= DIGIT_OFF;
            seg_q     <= SEG_OFF;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
        end
    end

    assign overflow = ovf_q;
    assign digit    = digit_q;
    assign segments = seg_q;

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// Bench for seven_seg_mux_n: directed loads with hand-computed display frames.
// The driver pushes {busy_len, overflow, frame} items; the monitor measures each
// busy run, then captures one full scan and compares against the queue head.
module tb_seven_seg_mux_n;

    localparam int EXP_W = 41;

    // Active-high segment codes {p,g,f,e,d,c,b,a}.
    localparam logic [7:0] S0 = 8'h3F;
    localparam logic [7:0] S1 = 8'h06;
    localparam logic [7:0] S2 = 8'h5B;
    localparam logic [7:0] S3 = 8'h4F;
    localparam logic [7:0] S4 = 8'h66;
    localparam logic [7:0] S7 = 8'h07;
    localparam logic [7:0] S9 = 8'h6F;
    localparam logic [7:0] SD = 8'h40;
    localparam logic [7:0] SB = 8'h00;
    localparam logic [7:0] SP = 8'h80;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic        enable;
    logic        busy;
    logic        overflow;
    logic [3:0]  digit;
    logic [7:0]  segments;
    logic [1:0]  dbg_state;

    logic [EXP_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int mon_done = 0;
    bit watch    = 0;
    int seen_one = 0;
    int seen_two = 0;

    seven_seg_mux_n #(
        .DIGITS           (4),
        .VALUE_W          (14),
        .REFRESH_W        (2),
        .DIGIT_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW   (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .dp_mask   (dp_mask),
        .blank_lz  (blank_lz),
        .enable    (enable),
        .busy      (busy),
        .overflow  (overflow),
        .digit     (digit),
        .segments  (segments),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] mk_exp(input int len, input bit ovf, input logic [31:0] f);
        return {8'(len), ovf, f};
    endfunction

    // Collect one full scan: f[k*8 +: 8] is the active-high pattern seen on digit k.
    task automatic capture_frame(output logic [31:0] f, output bit ok);
        bit [3:0]   seen;
        logic [3:0] want;
        seen = '0;
        f    = '0;
        for (int c = 0; c < 48 && seen != 4'hF; c++) begin
            for (int k = 0; k < 4; k++) begin
                want = ~(4'b0001 << k);
                if (digit === want) begin
                    f[k*8 +: 8] = ~segments;
                    seen[k]     = 1'b1;
                end
            end
            if (seen != 4'hF) @(negedge clk);
        end
        ok = (seen == 4'hF);
    endtask

    task automatic do_load(input logic [13:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_mon(input int target);
        int c;
        for (c = 0; c < 300 && mon_done < target; c++) @(negedge clk);
        if (mon_done < target) check("monitor_timeout", 64'(mon_done), 64'(target));
    endtask

    // Stops on the first negedge where digit 3 becomes active.
    task automatic sync_digit3(output bit ok);
        for (int c = 0; c < 40 && digit == 4'b0111; c++) @(negedge clk);
        for (int c = 0; c < 40 && digit != 4'b0111; c++) @(negedge clk);
        ok = (digit == 4'b0111);
    endtask

    // Counts patterns shown during the back-to-back window.
    always @(negedge clk) begin
        if (watch && digit != 4'hF) begin
            if (~segments == S2) seen_two++;
            if (~segments == S1) seen_one++;
        end
    end

    // Monitor: measure each busy run, then compare one captured scan to the queue.
    initial begin : monitor
        logic [EXP_W-1:0] item;
        logic [31:0]      got_f;
        bit               ok;
        bit               aborted;
        logic             ovf_s;
        int               len;
        forever begin
            @(negedge clk);
            if (rst && busy) begin
                len     = 1;
                aborted = 1'b0;
                while (1'b1) begin
                    @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (!busy) break;
                    len++;
                    if (len > 255) break;
                end
                if (aborted) begin
                    wait (rst === 1'b1);
                end else begin
                    @(negedge clk);
                    ovf_s = overflow;
                    capture_frame(got_f, ok);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 64'(got_f), 64'(0));
                    end else begin
                        item = exp_q.pop_front();
                        check("busy_len", 64'(len), 64'(item[40:33]));
                        check("overflow", 64'(ovf_s), 64'(item[32]));
                        check("frame_complete", 64'(ok), 64'(1));
                        check("frame", 64'(got_f), 64'(item[31:0]));
                    end
                    mon_done++;
                end
            end
        end
    end

    // Driver.
    initial begin : driver
        bit          ok;
        int          p;
        int          cnt;
        logic [31:0] f;
        logic [7:0]  seg_exp;

        rst      = 1'b0;
        value    = '0;
        load     = 1'b0;
        dp_mask  = '0;
        blank_lz = 1'b0;
        enable   = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_digit", 64'(digit), 64'(4'hF));
        check("rst_segments", 64'(segments), 64'(8'hFF));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1234, no blanking.
        exp_q.push_back(mk_exp(15, 1'b0, {S1, S2, S3, S4}));
        do_load(14'd1234);
        wait_mon(1);

        // 42 with blanking and a point on digit 2; then scan period.
        blank_lz = 1'b1;
        dp_mask  = 4'b0100;
        exp_q.push_back(mk_exp(15, 1'b0, {SB, SP, S4, S2}));
        do_load(14'd42);
        wait_mon(2);
        sync_digit3(ok);
        check("wrap_sync", 64'(ok), 64'(1));
        p = 0;
        do begin
            @(negedge clk);
            p++;
        end while (digit == 4'b0111 && p < 100);
        while (digit != 4'b0111 && p < 100) begin
            @(negedge clk);
            p++;
        end
        check("wrap_period", 64'(p), 64'(16));

        // Zero: only digit 0 lit.
        dp_mask = 4'b0000;
        exp_q.push_back(mk_exp(15, 1'b0, {SB, SB, SB, S0}));
        do_load(14'd0);
        wait_mon(3);

        // Overflow, then cleared by an in-range value.
        exp_q.push_back(mk_exp(15, 1'b1, {SD, SD, SD, SD}));
        do_load(14'd12000);
        wait_mon(4);
        exp_q.push_back(mk_exp(15, 1'b0, {S9, S9, S9, S9}));
        do_load(14'd9999);
        wait_mon(5);

        // Back-to-back: 111 then pending 333 (222 overwritten), one continuous busy run.
        blank_lz = 1'b0;
        seen_one = 0;
        seen_two = 0;
        watch    = 1'b1;
        exp_q.push_back(mk_exp(30, 1'b0, {S0, S3, S3, S3}));
        do_load(14'd111);
        repeat (2) @(negedge clk);
        do_load(14'd222);
        repeat (2) @(negedge clk);
        do_load(14'd333);
        wait_mon(6);
        watch = 1'b0;
        check("never_222", 64'(seen_two), 64'(0));
        check("saw_111", 64'(seen_one > 0), 64'(1));

        // Reset in the middle of SHIFT with a pending load.
        do_load(14'd4321);
        repeat (3) @(negedge clk);
        do_load(14'd5555);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_digit", 64'(digit), 64'(4'hF));
        check("midrst_segments", 64'(segments), 64'(8'hFF));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_state", 64'(dbg_state), 64'(0));
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("postrst_busy_cycles", 64'(cnt), 64'(0));
        capture_frame(f, ok);
        check("postrst_frame_complete", 64'(ok), 64'(1));
        check("postrst_frame", 64'(f), 64'({S0, S0, S0, S0}));
        exp_q.push_back(mk_exp(15, 1'b0, {S0, S0, S0, S7}));
        do_load(14'd7);
        wait_mon(7);

        // Display disable: outputs stay off while the scan keeps moving.
        sync_digit3(ok);
        check("en_sync", 64'(ok), 64'(1));
        enable = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (digit != 4'hF || segments != 8'hFF) cnt++;
        end
        check("disabled_outputs", 64'(cnt), 64'(0));
        enable = 1'b1;
        @(negedge clk);
        check("reenable_digit", 64'(digit), 64'(4'b1101));
        seg_exp = ~S0;
        check("reenable_segments", 64'(segments), 64'(seg_exp));

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
